fetch_phase_unit: RTL and testbench
===================================

FETCH_PHASE_UNIT -- requirements
Module: fetch_phase_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 8, program-counter and ROM address width.
REQ-002 SHALL provide parameter IR_W, default 15, instruction word width.
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CLK_FT  input  1  fetch phase level, synchronous to CLK.
REQ-006 SHALL have port CLK_DC  input  1  decode phase level, synchronous to CLK.
REQ-007 SHALL have port CLK_EX  input  1  execute phase level, synchronous to CLK.
REQ-008 SHALL have port CLK_WB  input  1  write-back phase level, synchronous to CLK.
REQ-009 SHALL have port JMP_EN  input  1  take-jump request, sampled at WB rise.
REQ-010 SHALL have port JMP_ADDR  input  PC_W  jump target.
REQ-011 SHALL have port HALT  input  1  halt request, sampled at WB rise.
REQ-012 SHALL have port ROM_DATA  input  IR_W  instruction word at ROM_ADDR.
REQ-013 SHALL have port ROM_ADDR  output  PC_W  instruction ROM address, combinationally equal to PC.
REQ-014 SHALL have port PC  output  PC_W  current program counter.
REQ-015 SHALL have port IR  output  IR_W  instruction register.
REQ-016 SHALL have port IR_VALID  output  1  IR holds a fetched instruction.
REQ-017 SHALL have port HALTED  output  1  core halted, sticky.
REQ-018 SHALL have port PHASE_ERR  output  1  phase-order violation seen, sticky.

Function
REQ-019 SHALL register each phase input every CLK; rise_X = CLK_X & ~prev_X, evaluated in the same cycle, action taken on that CLK edge.
REQ-020 SHALL run a 4-state phase FSM S_FT->S_DC->S_EX->S_WB->S_FT, advancing only on a lone rise of the expected phase.
REQ-021 SHALL, on a rise of any non-expected phase, or on two or more rises in one cycle, set PHASE_ERR and take no action: FSM, PC, IR unchanged.
REQ-022 SHALL, on a valid FT rise with HALTED=0, load IR<=ROM_DATA and set IR_VALID=1 at that edge.
REQ-023 SHALL, on a valid WB rise with HALTED=0, apply priority HALT > JMP_EN > increment.
REQ-024 SHALL, when HALT=1 at a valid WB rise, set HALTED=1, clear IR_VALID, and hold PC.
REQ-025 SHALL, when JMP_EN=1 and HALT=0 at a valid WB rise, load PC<=JMP_ADDR.
REQ-026 SHALL otherwise, at a valid WB rise, load PC<=PC+1 modulo 2^PC_W (2^PC_W-1 wraps to 0).
REQ-027 SHALL take no action on valid DC and EX rises beyond advancing the FSM.
REQ-028 SHALL, while HALTED=1, freeze PC, IR, IR_VALID, and keep tracking phases and PHASE_ERR.
REQ-029 SHALL ignore phase falling edges and steady levels; JMP_EN/HALT outside a valid WB rise have no effect.

Reset
REQ-030 SHALL, while RESET=1, force PC=0, IR=0, IR_VALID=0, HALTED=0, PHASE_ERR=0, FSM=S_FT, all prev_X=0, independent of CLK.
REQ-031 SHALL abandon any in-progress instruction on mid-cycle reset; after release, the first FT rise fetches address 0.
REQ-032 SHALL treat a phase input already high at reset release as rising on the first CLK edge after release.

Verification
REQ-033 SHALL cover: reset, then 4-phase rotation (FT,DC,EX,WB each high 2 CLKs), ROM[0]=0x1234, ROM[1]=0x0ABC -> IR=0x1234 after first FT rise, PC=1 after first WB rise, IR=0x0ABC after second FT rise.
REQ-034 SHALL cover: JMP_EN=1, JMP_ADDR=0x40 at WB rise -> PC=0x40 and next fetch reads ROM[0x40]; JMP_EN=1 at a DC rise -> ignored.
REQ-035 SHALL cover: PC=0xFF, no jump, WB rise -> PC=0x00.
REQ-036 SHALL cover: HALT=1 and JMP_EN=1 at WB rise -> HALTED=1, IR_VALID=0, PC unchanged; later FT rises leave IR unchanged.
REQ-037 SHALL cover: EX rise while FSM=S_DC, then FT and DC rising in the same cycle -> PHASE_ERR=1 stays high, FSM stays S_DC, PC/IR unchanged.
REQ-038 SHALL cover: RESET pulsed between FT and WB rises with PC=5 -> all outputs to reset values immediately; next FT rise fetches ROM[0].

Source files
------------

// File: rtl/fetch_phase_unit.sv
// Instruction fetch stage sequenced by four externally generated phase levels.
// FT loads IR from ROM, WB advances PC (halt > jump > increment); DC/EX only step the phase FSM.
module fetch_phase_unit #(
    parameter int PC_W = 8,
    parameter int IR_W = 15
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            CLK_FT,
    input  logic            CLK_DC,
    input  logic            CLK_EX,
    input  logic            CLK_WB,
    input  logic            JMP_EN,
    input  logic [PC_W-1:0] JMP_ADDR,
    input  logic            HALT,
    input  logic [IR_W-1:0] ROM_DATA,
    output logic [PC_W-1:0] ROM_ADDR,
    output logic [PC_W-1:0] PC,
    output logic [IR_W-1:0] IR,
    output logic            IR_VALID,
    output logic            HALTED,
    output logic            PHASE_ERR,
    output logic [1:0]      DBG_STATE
);

    typedef enum logic [1:0] {S_FT = 2'd0, S_DC = 2'd1, S_EX = 2'd2, S_WB = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [3:0]      prev_q;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic [3:0]      phase;
    logic [3:0]      rise;
    logic [3:0]      expect_mask;
    logic            valid_rise;

    // Bit order {WB, EX, DC, FT} so the expected bit index equals the state encoding.
    assign phase       = {CLK_WB, CLK_EX, CLK_DC, CLK_FT};
    assign rise        = phase & ~prev_q;
    assign expect_mask = 4'b0001 << state_q;
    assign valid_rise  = (rise == expect_mask);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        err_d      = err_q;
        if (valid_rise) begin
            case (state_q)
                S_FT: begin
                    state_d = S_DC;
                    if (!halted_q) begin
                        ir_d       = ROM_DATA;
                        ir_valid_d = 1'b1;
                    end
                end
                S_DC: state_d = S_EX;
                S_EX: state_d = S_WB;
                S_WB: begin
                    state_d = S_FT;
                    if (!halted_q) begin
                        if (HALT) begin
                            halted_d   = 1'b1;
                            ir_valid_d = 1'b0;
                        end else if (JMP_EN) begin
                            pc_d = JMP_ADDR;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
                default: state_d = S_FT;
            endcase
        end else if (rise != 4'b0000) begin
            // Out-of-order or simultaneous rises: flag only, no state change.
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_FT;
            prev_q     <= 4'b0000;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= phase;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign ROM_ADDR  = pc_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign IR_VALID  = ir_valid_q;
    assign HALTED    = halted_q;
    assign PHASE_ERR = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fetch_phase_unit.sv
// Bench for fetch_phase_unit: directed and randomized phase sequences checked
// against a phase-level behavioural model of the fetch stage.
module tb_fetch_phase_unit;

    logic        clk;
    logic        rst;
    logic        ft, dc, ex, wb;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
    logic        halt;
    logic [14:0] rom_data;
    logic [7:0]  rom_addr;
    logic [7:0]  pc;
    logic [14:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        phase_err;
    logic [1:0]  dbg_state;

    logic [14:0] rom [256];

    int checks   = 0;
    int failures = 0;

    // Reference model: phase index expected next (0=FT .. 3=WB) plus architectural state.
    int          m_phase;
    logic [3:0]  m_prev;
    logic [7:0]  m_pc;
    logic [14:0] m_ir;
    logic        m_valid;
    logic        m_halted;
    logic        m_err;

    fetch_phase_unit #(.PC_W(8), .IR_W(15)) dut (
        .CLK(clk), .RESET(rst),
        .CLK_FT(ft), .CLK_DC(dc), .CLK_EX(ex), .CLK_WB(wb),
        .JMP_EN(jmp_en), .JMP_ADDR(jmp_addr), .HALT(halt),
        .ROM_DATA(rom_data), .ROM_ADDR(rom_addr),
        .PC(pc), .IR(ir), .IR_VALID(ir_valid), .HALTED(halted),
        .PHASE_ERR(phase_err), .DBG_STATE(dbg_state)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_prev   = 4'b0000;
        m_pc     = 8'h00;
        m_ir     = 15'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic check_all();
        chk("pc",        32'(pc),        32'(m_pc));
        chk("rom_addr",  32'(rom_addr),  32'(m_pc));
        chk("ir",        32'(ir),        32'(m_ir));
        chk("ir_valid",  32'(ir_valid),  32'(m_valid));
        chk("halted",    32'(halted),    32'(m_halted));
        chk("phase_err", 32'(phase_err), 32'(m_err));
        chk("state",     32'(dbg_state), 32'(m_phase));
    endtask

    // One CLK cycle: drive levels (called at a falling edge), predict, clock, check.
    task automatic cyc(input logic [3:0] lv, input logic j, input logic [7:0] ja, input logic h);
        int n_rise;
        int which;
        {wb, ex, dc, ft} = lv;
        jmp_en   = j;
        jmp_addr = ja;
        halt     = h;
        n_rise = 0;
        which  = -1;
        for (int p = 0; p < 4; p++) begin
            if (lv[p] && !m_prev[p]) begin
                n_rise++;
                which = p;
            end
        end
        m_prev = lv;
        if (n_rise == 1 && which == m_phase) begin
            if (m_phase == 0 && !m_halted) begin
                m_ir    = rom[m_pc];
                m_valid = 1'b1;
            end
            if (m_phase == 3 && !m_halted) begin
                if (h) begin
                    m_halted = 1'b1;
                    m_valid  = 1'b0;
                end else if (j) begin
                    m_pc = ja;
                end else begin
                    m_pc = 8'((int'(m_pc) + 1) % 256);
                end
            end
            m_phase = (m_phase + 1) % 4;
        end else if (n_rise > 0) begin
            m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Full FT->DC->EX->WB rotation; jd is JMP_EN during DC, jw/h during WB.
    task automatic rotate(input int dur_lo, input int dur_hi, input logic jd,
                          input logic jw, input logic [7:0] ja, input logic h);
        int dur;
        for (int p = 0; p < 4; p++) begin
            dur = $urandom_range(dur_hi, dur_lo);
            for (int k = 0; k < dur; k++) begin
                case (p)
                    1:       cyc(4'b0001 << p, jd, ja, 1'b0);
                    3:       cyc(4'b0001 << p, jw, ja, h);
                    default: cyc(4'b0001 << p, $urandom_range(1, 0) == 1, 8'($urandom), 1'b0);
                endcase
            end
        end
    endtask

    // Asynchronous reset asserted away from the clock edge, checked before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_pc_zero", 32'(pc), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 15'($urandom);
        rom[0] = 15'h1234;
        rom[1] = 15'h0ABC;
        rst = 1'b1;
        {wb, ex, dc, ft} = 4'b0000;
        jmp_en = 1'b0;
        jmp_addr = 8'h00;
        halt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Basic rotation: fetch ROM[0], increment, fetch ROM[1].
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        chk("first_fetch_ir", 32'(ir), 32'h1234);
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        for (int p = 1; p < 4; p++) repeat (2) cyc(4'b0001 << p, 1'b0, 8'h00, 1'b0);
        chk("first_wb_pc", 32'(pc), 32'h1);
        rotate(2, 2, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("second_fetch_ir", 32'(ir), 32'h0ABC);

        // Jump at WB taken; jump request at DC ignored.
        rotate(2, 2, 1'b1, 1'b1, 8'h40, 1'b0);
        chk("jump_pc", 32'(pc), 32'h40);
        rotate(2, 2, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("jump_fetch_ir", 32'(ir), 32'(rom[8'h40]));
        chk("dc_jump_ignored_pc", 32'(pc), 32'h41);

        // PC wrap from 0xFF.
        rotate(2, 2, 1'b0, 1'b1, 8'hFF, 1'b0);
        rotate(2, 2, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pc_wrap", 32'(pc), 32'h00);

        // Randomized well-ordered rotations with random durations and jumps.
        for (int r = 0; r < 60; r++)
            rotate(1, 3, $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, 8'($urandom), 1'b0);

        // Phase-order violations: EX in S_DC, then FT+DC together.
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        cyc(4'b0000, 1'b0, 8'h00, 1'b0);
        cyc(4'b0100, 1'b0, 8'h00, 1'b0);
        chk("err_ex_in_dc", 32'(phase_err), 32'h1);
        cyc(4'b0000, 1'b0, 8'h00, 1'b0);
        cyc(4'b0011, 1'b1, 8'h12, 1'b1);
        cyc(4'b0000, 1'b0, 8'h00, 1'b0);
        chk("err_state_dc", 32'(dbg_state), 32'h1);
        chk("err_sticky", 32'(phase_err), 32'h1);

        // Mid-instruction reset with PC=5, then fetch from 0.
        do_reset();
        rotate(2, 2, 1'b0, 1'b1, 8'h05, 1'b0);
        chk("pc_five", 32'(pc), 32'h5);
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        cyc(4'b0000, 1'b0, 8'h00, 1'b0);
        do_reset();
        rotate(2, 2, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_reset_fetch", 32'(ir), 32'h1234);

        // FT already high at reset release counts as a rise.
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        do_reset();
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        chk("level_high_release_ir", 32'(ir), 32'h1234);
        chk("level_high_release_valid", 32'(ir_valid), 32'h1);

        // Halt beats jump; then frozen across further rotations.
        cyc(4'b0010, 1'b0, 8'h00, 1'b0);
        cyc(4'b0100, 1'b0, 8'h00, 1'b0);
        cyc(4'b1000, 1'b1, 8'h33, 1'b1);
        chk("halted_set", 32'(halted), 32'h1);
        chk("halt_valid_clr", 32'(ir_valid), 32'h0);
        chk("halt_pc_held", 32'(pc), 32'h0);
        rotate(2, 2, 1'b1, 1'b1, 8'h55, 1'b0);
        rotate(1, 3, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("halt_ir_frozen", 32'(ir), 32'h1234);
        chk("halt_pc_frozen", 32'(pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
